// File: rtl/prefix_adder_seq_pkg.sv
// Shared constants, FSM encoding and the generate/propagate cell for the
// iterative Kogge-Stone adder.
package prefix_adder_seq_pkg;

    localparam int PAS_LEN_DATA = 32;

    typedef enum logic [1:0] {
        PAS_IDLE   = 2'd0,
        PAS_PREFIX = 2'd1,
        PAS_DONE   = 2'd2
    } pas_state_t;

    // Stage counter must reach STAGES without wrapping, hence the extra bit.
    function automatic int pasCntWidth(input int len);
        return $clog2($clog2(len)) + 1;
    endfunction

    // Combines a high group {gHi,pHi} with the group below it {gLo,pLo}.
    // Returns {g, p} of the merged group.
    function automatic logic [1:0] gpCell(input logic gHi, input logic pHi,
                                          input logic gLo, input logic pLo);
        return {gHi | (pHi & gLo), pHi & pLo};
    endfunction

endpackage

// File: rtl/prefix_adder_seq_stage.sv
// One Kogge-Stone prefix level whose span d = 1<<k is chosen at run time.
// Bits below the span see an identity operand (g=0, p=1) so they hold.
module prefix_adder_seq_stage
    import prefix_adder_seq_pkg::*;
#(
    parameter  int LEN_DATA = PAS_LEN_DATA,
    localparam int STAGES   = $clog2(LEN_DATA),
    localparam int CNT_W    = pasCntWidth(LEN_DATA)
) (
    input  logic [LEN_DATA-1:0] i_g,
    input  logic [LEN_DATA-1:0] i_p,
    input  logic [CNT_W-1:0]    i_k,
    output logic [LEN_DATA-1:0] o_g,
    output logic [LEN_DATA-1:0] o_p
);

    logic [STAGES-1:0][LEN_DATA-1:0] w_gLo;
    logic [STAGES-1:0][LEN_DATA-1:0] w_pLo;
    logic [LEN_DATA-1:0]             w_gSel;
    logic [LEN_DATA-1:0]             w_pSel;

    for (genvar s = 0; s < STAGES; s++) begin : g_dist
        for (genvar i = 0; i < LEN_DATA; i++) begin : g_bit
            if (i >= (1 << s)) begin : g_far
                assign w_gLo[s][i] = i_g[i - (1 << s)];
                assign w_pLo[s][i] = i_p[i - (1 << s)];
            end else begin : g_near
                assign w_gLo[s][i] = 1'b0;
                assign w_pLo[s][i] = 1'b1;
            end
        end
    end

    // Pick the i-d operand vector for the current distance; an out-of-range
    // k falls back to the identity operand so every bit simply holds.
    always_comb begin
        w_gSel = '0;
        w_pSel = '1;
        for (int s = 0; s < STAGES; s++) begin
            if (i_k == CNT_W'(s)) begin
                w_gSel = w_gLo[s];
                w_pSel = w_pLo[s];
            end
        end
    end

    for (genvar i = 0; i < LEN_DATA; i++) begin : g_cell
        assign {o_g[i], o_p[i]} = gpCell(i_g[i], i_p[i], w_gSel[i], w_pSel[i]);
    end

endmodule

// File: rtl/prefix_adder_seq.sv
// Iterative Kogge-Stone adder: a single variable-distance prefix stage is
// reused for log2(LEN_DATA) cycles between a valid/ready input and output.
// Optional feature: define PREFIX_ADD_SUB_EN to add the 'sub' port (A-B).
module prefix_adder_seq
    import prefix_adder_seq_pkg::*;
#(
    parameter int LEN_DATA = PAS_LEN_DATA
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LEN_DATA-1:0] a,
    input  logic [LEN_DATA-1:0] b,
    input  logic                cin,
`ifdef PREFIX_ADD_SUB_EN
    input  logic                sub,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LEN_DATA-1:0] sum,
    output logic                cout,
    output logic                busy
);

    localparam int STAGES = $clog2(LEN_DATA);
    localparam int CNT_W  = pasCntWidth(LEN_DATA);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(STAGES - 1);

    pas_state_t          r_state;
    pas_state_t          w_stateNext;
    logic [CNT_W-1:0]    r_k;
    logic [LEN_DATA-1:0] r_g;
    logic [LEN_DATA-1:0] r_p;
    logic [LEN_DATA-1:0] r_p0;
    logic                r_cin;
    logic [LEN_DATA-1:0] r_sum;
    logic                r_cout;

    logic                w_accept;
    logic                w_lastStage;
    logic [LEN_DATA-1:0] w_bEff;
    logic                w_cinEff;
    logic [LEN_DATA-1:0] w_gInit;
    logic [LEN_DATA-1:0] w_gNext;
    logic [LEN_DATA-1:0] w_pNext;

`ifdef PREFIX_ADD_SUB_EN
    assign w_bEff   = sub ? ~b : b;
    assign w_cinEff = sub ? 1'b1 : cin;
`else
    assign w_bEff   = b;
    assign w_cinEff = cin;
`endif

    // Initial generate vector; carry-in is folded into bit 0 so the prefix
    // result at bit i is directly the carry out of bit i.
    always_comb begin
        w_gInit    = a & w_bEff;
        w_gInit[0] = (a[0] & w_bEff[0]) | ((a[0] ^ w_bEff[0]) & w_cinEff);
    end

    prefix_adder_seq_stage #(.LEN_DATA(LEN_DATA)) u_stage (
        .i_g (r_g),
        .i_p (r_p),
        .i_k (r_k),
        .o_g (w_gNext),
        .o_p (w_pNext)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= PAS_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Next-state and handshake outputs; only IDLE accepts, only DONE offers.
    always_comb begin
        w_stateNext = r_state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        out_valid   = 1'b0;
        w_accept    = 1'b0;
        w_lastStage = 1'b0;
        case (r_state)
            PAS_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_stateNext = PAS_PREFIX;
                end
            end
            PAS_PREFIX: begin
                busy = 1'b1;
                if (r_k == LAST_K) begin
                    w_lastStage = 1'b1;
                    w_stateNext = PAS_DONE;
                end
            end
            PAS_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_stateNext = PAS_IDLE;
                end
            end
            default: w_stateNext = PAS_IDLE;
        endcase
    end

    // Operand capture, in-place prefix iterations and result registers;
    // the result is only rewritten on the last prefix stage so it holds
    // through DONE and the following IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_k    <= '0;
            r_g    <= '0;
            r_p    <= '0;
            r_p0   <= '0;
            r_cin  <= 1'b0;
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else if (w_accept) begin
            r_k    <= '0;
            r_g    <= w_gInit;
            r_p    <= a ^ w_bEff;
            r_p0   <= a ^ w_bEff;
            r_cin  <= w_cinEff;
        end else if (r_state == PAS_PREFIX) begin
            r_g <= w_gNext;
            r_p <= w_pNext;
            r_k <= r_k + CNT_W'(1);
            if (w_lastStage) begin
                r_sum  <= r_p0 ^ {w_gNext[LEN_DATA-2:0], r_cin};
                r_cout <= w_gNext[LEN_DATA-1];
            end
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_prefix_adder_seq.sv
// Directed and random checks for the iterative Kogge-Stone adder.
// Subtract vectors are included when PREFIX_ADD_SUB_EN is defined.
module tb_prefix_adder_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
`ifdef PREFIX_ADD_SUB_EN
    logic        sub;
`endif
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        busy;

    int nChecks = 0;
    int nErrors = 0;

    localparam int N_RAND = 1000;

    // 10 ns clock.
    always #5 clk = ~clk;

    prefix_adder_seq #(.LEN_DATA(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef PREFIX_ADD_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        nChecks++;
        if (observed !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Waits (bounded) for in_ready, presents one operand set for one edge.
    // Returns at the falling edge right after the accepting rising edge.
    task automatic applyStimulus(input logic [31:0] aIn, input logic [31:0] bIn,
                                 input logic cinIn);
        int n = 0;
        while (!in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) checkOutput("accept_timeout", 64'(in_ready), 64'd1);
        a        = aIn;
        b        = bIn;
        cin      = cinIn;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts rising edges from the accept edge (counted as 1) until out_valid,
    // then compares latency and {cout,sum}. Leaves the result pending.
    task automatic awaitResult(input string tag, input logic [32:0] expected,
                               input int expLatency);
        int n = 1;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput({tag, "_lat"}, 64'(n), 64'(expLatency));
        checkOutput({tag, "_sum"}, 64'({cout, sum}), 64'(expected));
    endtask

    // Consumes the pending result with a one-cycle out_ready pulse.
    task automatic releaseResult();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [32:0] expSum;
        int          gap;
        int          nRes;
        int          guard;
        logic        sawValid;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
`ifdef PREFIX_ADD_SUB_EN
        sub       = 1'b0;
`endif
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("rst_in_ready",  64'(in_ready),  64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_busy",      64'(busy),      64'd0);
        checkOutput("rst_sum",       64'({cout, sum}), 64'd0);

        // All-ones plus one: carry ripples across the whole word.
        applyStimulus(32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
        checkOutput("busy_in_prefix", 64'(busy), 64'd1);
        checkOutput("no_ready_in_prefix", 64'(in_ready), 64'd0);
        awaitResult("ones", {1'b1, 32'h0000_0000}, 6);
        releaseResult();

        applyStimulus(32'h1234_5678, 32'h0F0F_0F0F, 1'b1);
        awaitResult("mixed", {1'b0, 32'h2143_6588}, 6);
        releaseResult();

        // Back-pressure in DONE: result stable, new operands ignored.
        applyStimulus(32'h8000_0000, 32'h8000_0000, 1'b1);
        awaitResult("stall", {1'b1, 32'h0000_0001}, 6);
        for (int c = 0; c < 4; c++) begin
            in_valid = c[0];
            a        = 32'h1111_1111;
            b        = 32'h2222_2222;
            cin      = 1'b0;
            @(negedge clk);
            checkOutput("stall_valid",    64'(out_valid),    64'd1);
            checkOutput("stall_sum",      64'({cout, sum}),  64'h1_0000_0001);
            checkOutput("stall_in_ready", 64'(in_ready),     64'd0);
        end

        // out_ready and in_valid together: the new op waits for IDLE.
        a         = 32'd3;
        b         = 32'd4;
        cin       = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("overlap_in_ready",  64'(in_ready),    64'd1);
        checkOutput("overlap_out_valid", 64'(out_valid),   64'd0);
        checkOutput("overlap_hold_sum",  64'({cout, sum}), 64'h1_0000_0001);
        @(negedge clk);
        in_valid = 1'b0;
        awaitResult("overlap", {1'b0, 32'h0000_0007}, 6);
        releaseResult();

        // Reset while the prefix is at stage 2 discards the operation.
        applyStimulus(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_in_ready",  64'(in_ready),    64'd1);
        checkOutput("midrst_out_valid", 64'(out_valid),   64'd0);
        checkOutput("midrst_busy",      64'(busy),        64'd0);
        checkOutput("midrst_sum",       64'({cout, sum}), 64'd0);
        sawValid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        checkOutput("midrst_no_result", 64'(sawValid), 64'd0);
        applyStimulus(32'hDEAD_BEEF, 32'h0123_4567, 1'b0);
        awaitResult("after_rst", {1'b0, 32'hDFD1_0456}, 6);
        releaseResult();

`ifdef PREFIX_ADD_SUB_EN
        // Subtraction: cout=1 means no borrow; the cin port is ignored.
        sub = 1'b1;
        applyStimulus(32'd5, 32'd7, 1'b0);
        awaitResult("sub_neg", {1'b0, 32'hFFFF_FFFE}, 6);
        releaseResult();
        applyStimulus(32'd7, 32'd5, 1'b0);
        awaitResult("sub_pos", {1'b1, 32'h0000_0002}, 6);
        releaseResult();
        sub = 1'b0;
`endif

        // Random back-to-back ops with out_ready tied high.
        out_ready = 1'b1;
        a         = $urandom;
        b         = $urandom;
        cin       = 1'($urandom_range(0, 1));
        expSum    = {1'b0, a} + {1'b0, b} + 33'(cin);
        in_valid  = 1'b1;
        gap       = 0;
        nRes      = 0;
        guard     = 0;
        while (nRes < N_RAND && guard < 20000) begin
            @(negedge clk);
            guard++;
            gap++;
            if (out_valid) begin
                checkOutput("rand_sum", 64'({cout, sum}), 64'(expSum));
                nRes++;
            end
            if (in_ready) begin
                checkOutput("rand_gap", 64'(gap), 64'd7);
                gap    = 0;
                a      = $urandom;
                b      = $urandom;
                cin    = 1'($urandom_range(0, 1));
                expSum = {1'b0, a} + {1'b0, b} + 33'(cin);
            end
        end
        in_valid = 1'b0;
        checkOutput("rand_count", 64'(nRes), 64'(N_RAND));
        @(negedge clk);
        out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
